mem_read_arbiter: RTL and testbench

- Shares the single main-memory read bus (256-bit line reads) between ICache and DCache refill engines.
- Captures each requester's one-cycle ren pulse into a pending slot and grants one slot at a time.
- Issues one bus read per grant and routes the returning line back to the granted cache only.
- Sits between both caches' read-bus interfaces and the memory/bridge read port.

---
 rtl/mem_read_arbiter_pkg.sv | 15 +
 rtl/mem_read_arbiter_if.sv | 28 ++
 rtl/mem_read_arbiter_req_slot.sv | 48 ++++
 rtl/mem_read_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// mem_arb_pkg: shared types for the memory read arbiter.
// FSM state encodings, requester IDs and the idle read-enable value.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_t;

  localparam logic       REQ_IC   = 1'b0;
  localparam logic       REQ_DC   = 1'b1;
  localparam logic [3:0] REN_NONE = 4'h0;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: line read bus (rrdy/ren/raddr/rvalid/rdata).
// master issues ren/raddr; slave returns rrdy/rvalid/rdata.
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  logic              rrdy;
  logic [3:0]        ren;
  logic [ADDR_W-1:0] raddr;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  rrdy,
    output ren,
    output raddr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    output rrdy,
    input  ren,
    input  raddr,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/mem_read_arbiter_req_slot.sv
// mem_arb_req_slot: one pending {ren, raddr} request with full flag.
// Ports: cpu_clk/cpu_rst, ren_i/addr_i capture, clr_i, full_o/ren_o/addr_o.
module mem_arb_req_slot
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic [3:0]        ren_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              clr_i,
  output logic              full_o,
  output logic [3:0]        ren_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              full_q;
  logic [3:0]        ren_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      full_q <= 1'b0;
      ren_q  <= REN_NONE;
      addr_q <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
      ren_q  <= REN_NONE;
      addr_q <= '0;
    end else if (!full_q && ren_i != REN_NONE) begin
      full_q <= 1'b1;
      ren_q  <= ren_i;
      addr_q <= addr_i;
    end
  end

  assign full_o = full_q;
  assign ren_o  = ren_q;
  assign addr_o = addr_q;

  // A request arriving while the slot is occupied is dropped.
  a_no_overrun: assert property (
    @(posedge cpu_clk) disable iff (cpu_rst)
    !(full_q && ren_i != REN_NONE)
  );

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one line-read bus between ICache and DCache.
// Ports: cpu_clk, cpu_rst, ic/dc (slave), mem (master). Macro MEM_ARB_RR_EN.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input logic                cpu_clk,
  input logic                cpu_rst,
  mem_read_arbiter_if.slave  ic,
  mem_read_arbiter_if.slave  dc,
  mem_read_arbiter_if.master mem
);

  logic              ic_full, dc_full;
  logic [3:0]        ic_sren, dc_sren;
  logic [ADDR_W-1:0] ic_saddr, dc_saddr;
  logic              ic_clr, dc_clr;

  state_t            state_q;
  logic              gnt_q;
  logic [3:0]        mem_ren_q;
  logic [ADDR_W-1:0] mem_raddr_q;
  logic              ic_rvalid_q, dc_rvalid_q;
  logic [DATA_W-1:0] ic_rdata_q, dc_rdata_q;
  logic              sel;
  logic              done;

  mem_arb_req_slot #(.ADDR_W(ADDR_W)) u_ic_slot (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .ren_i   (ic.ren),
    .addr_i  (ic.raddr),
    .clr_i   (ic_clr),
    .full_o  (ic_full),
    .ren_o   (ic_sren),
    .addr_o  (ic_saddr)
  );

  mem_arb_req_slot #(.ADDR_W(ADDR_W)) u_dc_slot (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .ren_i   (dc.ren),
    .addr_i  (dc.raddr),
    .clr_i   (dc_clr),
    .full_o  (dc_full),
    .ren_o   (dc_sren),
    .addr_o  (dc_saddr)
  );

  assign done   = (state_q == WAIT) && mem.rvalid;
  assign ic_clr = done && (gnt_q == REQ_IC);
  assign dc_clr = done && (gnt_q == REQ_DC);

`ifdef MEM_ARB_RR_EN
  logic ptr_q;

  always_comb begin
    sel = REQ_IC;
    unique case (1'b1)
      ic_full && dc_full: sel = ~ptr_q;
      dc_full:            sel = REQ_DC;
      default:            sel = REQ_IC;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst)
      ptr_q <= REQ_IC;
    else if (state_q == IDLE && (ic_full || dc_full) && mem.rrdy)
      ptr_q <= sel;
  end
`else
  assign sel = dc_full ? REQ_DC : REQ_IC;
`endif

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= IDLE;
      gnt_q       <= REQ_IC;
      mem_ren_q   <= REN_NONE;
      mem_raddr_q <= '0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if ((ic_full || dc_full) && mem.rrdy) begin
            gnt_q       <= sel;
            mem_ren_q   <= (sel == REQ_DC) ? dc_sren : ic_sren;
            mem_raddr_q <= (sel == REQ_DC) ? dc_saddr : ic_saddr;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_ren_q <= REN_NONE;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (mem.rvalid) begin
            if (gnt_q == REQ_DC) begin
              dc_rdata_q  <= mem.rdata;
              dc_rvalid_q <= 1'b1;
            end else begin
              ic_rdata_q  <= mem.rdata;
              ic_rvalid_q <= 1'b1;
            end
            mem_raddr_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic.rrdy   = ~ic_full;
  assign dc.rrdy   = ~dc_full;
  assign ic.rvalid = ic_rvalid_q;
  assign dc.rvalid = dc_rvalid_q;
  assign ic.rdata  = ic_rdata_q;
  assign dc.rdata  = dc_rdata_q;
  assign mem.ren   = mem_ren_q;
  assign mem.raddr = mem_raddr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: randomized self-checking bench for mem_read_arbiter.
// Memory side is modelled in-bench; grant order comes from a rule model.
module tb_mem_read_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  mem_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ic_if ();
  mem_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dc_if ();
  mem_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .ic      (ic_if),
    .dc      (dc_if),
    .mem     (mem_if)
  );

  int total  = 0;
  int passed = 0;
  bit m_last = 1'b0;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic bit pick(bit icp, bit dcp);
    if (icp && dcp) begin
`ifdef MEM_ARB_RR_EN
      return ~m_last;
`else
      return 1'b1;
`endif
    end
    return dcp;
  endfunction

  task automatic test_reset();
    tick();
    total++; if (ic_if.rrdy !== 1'b1) $display("FAIL rst_ic_rrdy got %b exp 1", ic_if.rrdy); else passed++;
    total++; if (dc_if.rrdy !== 1'b1) $display("FAIL rst_dc_rrdy got %b exp 1", dc_if.rrdy); else passed++;
    total++; if (mem_if.ren !== 4'h0) $display("FAIL rst_mem_ren got %h exp 0", mem_if.ren); else passed++;
    total++; if (mem_if.raddr !== '0) $display("FAIL rst_mem_raddr got %h exp 0", mem_if.raddr); else passed++;
    total++; if ({ic_if.rvalid, dc_if.rvalid} !== 2'b00) $display("FAIL rst_rvalid got %b exp 00", {ic_if.rvalid, dc_if.rvalid}); else passed++;
    total++; if (ic_if.rdata !== '0 || dc_if.rdata !== '0) $display("FAIL rst_rdata got %h/%h exp 0", ic_if.rdata, dc_if.rdata); else passed++;
    cpu_rst = 1'b0;
    m_last  = REQ_IC;
    tick();
  endtask

  task automatic test_read(input bit is_dc, input logic [3:0] ren,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int dly);
    logic rv_o;
    logic rv_n;
    if (is_dc) begin dc_if.ren = ren; dc_if.raddr = addr; end
    else begin ic_if.ren = ren; ic_if.raddr = addr; end
    total++; if ((is_dc ? dc_if.rrdy : ic_if.rrdy) !== 1'b1) $display("FAIL rd_rrdy0 got 0 exp 1"); else passed++;
    tick();
    ic_if.ren = 4'h0;
    dc_if.ren = 4'h0;
    total++; if ((is_dc ? dc_if.rrdy : ic_if.rrdy) !== 1'b0) $display("FAIL rd_rrdy1 got 1 exp 0"); else passed++;
    total++; if (mem_if.ren !== 4'h0) $display("FAIL rd_ren_c1 got %h exp 0", mem_if.ren); else passed++;
    tick();
    total++; if (mem_if.ren !== ren) $display("FAIL rd_ren_c2 got %h exp %h", mem_if.ren, ren); else passed++;
    total++; if (mem_if.raddr !== addr) $display("FAIL rd_addr_c2 got %h exp %h", mem_if.raddr, addr); else passed++;
    tick();
    total++; if (mem_if.ren !== 4'h0) $display("FAIL rd_ren_c3 got %h exp 0", mem_if.ren); else passed++;
    repeat (dly) tick();
    total++; if (mem_if.raddr !== addr) $display("FAIL rd_addr_wait got %h exp %h", mem_if.raddr, addr); else passed++;
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = data;
    tick();
    mem_if.rvalid = 1'b0;
    rv_o = is_dc ? dc_if.rvalid : ic_if.rvalid;
    rv_n = is_dc ? ic_if.rvalid : dc_if.rvalid;
    total++; if (rv_o !== 1'b1) $display("FAIL rd_rvalid got %b exp 1", rv_o); else passed++;
    total++; if (rv_n !== 1'b0) $display("FAIL rd_other_rvalid got %b exp 0", rv_n); else passed++;
    total++; if ((is_dc ? dc_if.rdata : ic_if.rdata) !== data) $display("FAIL rd_rdata got %h exp %h", is_dc ? dc_if.rdata : ic_if.rdata, data); else passed++;
    total++; if (mem_if.raddr !== '0) $display("FAIL rd_addr_idle got %h exp 0", mem_if.raddr); else passed++;
    total++; if ((is_dc ? dc_if.rrdy : ic_if.rrdy) !== 1'b1) $display("FAIL rd_rrdy_end got 0 exp 1"); else passed++;
    m_last = is_dc;
    tick();
    total++; if ((is_dc ? dc_if.rvalid : ic_if.rvalid) !== 1'b0) $display("FAIL rd_rvalid_pulse got 1 exp 0"); else passed++;
    total++; if ((is_dc ? dc_if.rdata : ic_if.rdata) !== data) $display("FAIL rd_rdata_hold got %h exp %h", is_dc ? dc_if.rdata : ic_if.rdata, data); else passed++;
  endtask

  task automatic test_pair(input logic [AW-1:0] ia, input logic [AW-1:0] da);
    logic [AW-1:0] got[$];
    logic [AW-1:0] exp_addr[2];
    bit            exp_dst[2];
    logic [DW-1:0] sent;
    bit            busy;
    int            cnt;
    int            done;
    exp_dst[0]  = pick(1'b1, 1'b1);
    exp_dst[1]  = ~exp_dst[0];
    exp_addr[0] = exp_dst[0] ? da : ia;
    exp_addr[1] = exp_dst[1] ? da : ia;
    ic_if.ren = 4'($urandom_range(1, 15)); ic_if.raddr = ia;
    dc_if.ren = 4'($urandom_range(1, 15)); dc_if.raddr = da;
    busy = 1'b0; cnt = 0; done = 0; sent = '0;
    for (int c = 0; c < 60 && done < 2; c++) begin
      tick();
      ic_if.ren = 4'h0;
      dc_if.ren = 4'h0;
      mem_if.rvalid = 1'b0;
      if (ic_if.rvalid || dc_if.rvalid) begin
        total++; if (dc_if.rvalid !== exp_dst[done] || ic_if.rvalid !== ~exp_dst[done]) $display("FAIL pair_route got ic=%b dc=%b exp dc=%b", ic_if.rvalid, dc_if.rvalid, exp_dst[done]); else passed++;
        total++; if ((exp_dst[done] ? dc_if.rdata : ic_if.rdata) !== sent) $display("FAIL pair_rdata got %h exp %h", exp_dst[done] ? dc_if.rdata : ic_if.rdata, sent); else passed++;
        done++;
        busy = 1'b0;
      end
      if (mem_if.ren !== 4'h0) begin
        total++; if (busy) $display("FAIL pair_outstanding got 2 exp 1"); else passed++;
        got.push_back(mem_if.raddr);
        busy = 1'b1;
        cnt  = $urandom_range(1, 4);
      end else if (busy && cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sent = rand_line();
          mem_if.rvalid = 1'b1;
          mem_if.rdata  = sent;
        end
      end
    end
    mem_if.rvalid = 1'b0;
    total++; if (done != 2) $display("FAIL pair_timeout got %0d exp 2", done); else passed++;
    total++; if (got.size() != 2) $display("FAIL pair_count got %0d exp 2", got.size()); else passed++;
    if (got.size() == 2) begin
      total++; if (got[0] !== exp_addr[0]) $display("FAIL pair_first got %h exp %h", got[0], exp_addr[0]); else passed++;
      total++; if (got[1] !== exp_addr[1]) $display("FAIL pair_second got %h exp %h", got[1], exp_addr[1]); else passed++;
    end
    m_last = exp_dst[1];
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] r;
    r = 4'($urandom_range(1, 15));
    mem_if.rrdy = 1'b0;
    ic_if.ren = r; ic_if.raddr = 32'h0000_0440;
    for (int c = 1; c <= 10; c++) begin
      tick();
      ic_if.ren = 4'h0;
      total++; if (mem_if.ren !== 4'h0) $display("FAIL bp_ren c%0d got %h exp 0", c, mem_if.ren); else passed++;
      total++; if (ic_if.rrdy !== 1'b0) $display("FAIL bp_rrdy c%0d got 1 exp 0", c); else passed++;
    end
    mem_if.rrdy = 1'b1;
    tick();
    total++; if (mem_if.ren !== r) $display("FAIL bp_issue got %h exp %h", mem_if.ren, r); else passed++;
    tick();
    mem_if.rvalid = 1'b1; mem_if.rdata = rand_line();
    tick();
    mem_if.rvalid = 1'b0;
    total++; if (ic_if.rvalid !== 1'b1) $display("FAIL bp_rvalid got 0 exp 1"); else passed++;
    m_last = REQ_IC;
    tick();
  endtask

  task automatic test_overlap();
    logic [DW-1:0] d;
    ic_if.ren = 4'h3; ic_if.raddr = 32'h0000_0800;
    tick(); ic_if.ren = 4'h0;
    tick();
    tick();
    dc_if.ren = 4'hC; dc_if.raddr = 32'h0000_0900;
    tick(); dc_if.ren = 4'h0;
    total++; if (dc_if.rrdy !== 1'b0) $display("FAIL ov_dc_rrdy got 1 exp 0"); else passed++;
    mem_if.rvalid = 1'b1; mem_if.rdata = rand_line();
    tick(); mem_if.rvalid = 1'b0;
    total++; if (ic_if.rvalid !== 1'b1) $display("FAIL ov_ic_rvalid got 0 exp 1"); else passed++;
    total++; if (mem_if.ren !== 4'h0) $display("FAIL ov_ren_idle got %h exp 0", mem_if.ren); else passed++;
    tick();
    total++; if (mem_if.ren !== 4'hC) $display("FAIL ov_dc_issue got %h exp c", mem_if.ren); else passed++;
    total++; if (mem_if.raddr !== 32'h0000_0900) $display("FAIL ov_dc_addr got %h exp 900", mem_if.raddr); else passed++;
    tick();
    d = rand_line();
    mem_if.rvalid = 1'b1; mem_if.rdata = d;
    tick(); mem_if.rvalid = 1'b0;
    total++; if (dc_if.rvalid !== 1'b1 || dc_if.rdata !== d) $display("FAIL ov_dc_done got %b/%h exp 1/%h", dc_if.rvalid, dc_if.rdata, d); else passed++;
    m_last = REQ_DC;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] ic_prev;
    ic_prev = ic_if.rdata;
    ic_if.ren = 4'h5; ic_if.raddr = 32'h0000_0a00;
    tick(); ic_if.ren = 4'h0;
    tick();
    tick();
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    m_last  = REQ_IC;
    total++; if ({ic_if.rrdy, dc_if.rrdy} !== 2'b11) $display("FAIL rm_rrdy got %b exp 11", {ic_if.rrdy, dc_if.rrdy}); else passed++;
    total++; if (mem_if.ren !== 4'h0) $display("FAIL rm_ren got %h exp 0", mem_if.ren); else passed++;
    ic_prev = ic_if.rdata;
    total++; if (ic_prev !== '0) $display("FAIL rm_rdata_clr got %h exp 0", ic_prev); else passed++;
    mem_if.rvalid = 1'b1; mem_if.rdata = rand_line();
    tick(); mem_if.rvalid = 1'b0;
    total++; if ({ic_if.rvalid, dc_if.rvalid} !== 2'b00) $display("FAIL rm_stale got %b exp 00", {ic_if.rvalid, dc_if.rvalid}); else passed++;
    total++; if (ic_if.rdata !== ic_prev) $display("FAIL rm_rdata got %h exp %h", ic_if.rdata, ic_prev); else passed++;
    tick();
    total++; if (mem_if.ren !== 4'h0) $display("FAIL rm_ren_after got %h exp 0", mem_if.ren); else passed++;
  endtask

  task automatic test_stray();
    logic [DW-1:0] ip, dp;
    ip = ic_if.rdata;
    dp = dc_if.rdata;
    mem_if.rvalid = 1'b1; mem_if.rdata = rand_line();
    tick(); mem_if.rvalid = 1'b0;
    total++; if ({ic_if.rvalid, dc_if.rvalid} !== 2'b00) $display("FAIL stray_rvalid got %b exp 00", {ic_if.rvalid, dc_if.rvalid}); else passed++;
    total++; if (ic_if.rdata !== ip || dc_if.rdata !== dp) $display("FAIL stray_rdata got %h/%h exp %h/%h", ic_if.rdata, dc_if.rdata, ip, dp); else passed++;
    total++; if (mem_if.ren !== 4'h0) $display("FAIL stray_ren got %h exp 0", mem_if.ren); else passed++;
    tick();
  endtask

  initial begin
    ic_if.ren = 4'h0; ic_if.raddr = '0;
    dc_if.ren = 4'h0; dc_if.raddr = '0;
    mem_if.rrdy = 1'b1; mem_if.rvalid = 1'b0; mem_if.rdata = '0;
    test_reset();
    test_read(1'b0, 4'hF, 32'h0000_0120, {32{8'hA5}}, 2);
    test_pair(32'h0000_0100, 32'h0000_0200);
    test_pair(32'h0000_0100, 32'h0000_0200);
    for (int i = 0; i < 6; i++)
      test_read(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                $urandom, rand_line(), $urandom_range(0, 5));
    for (int i = 0; i < 3; i++)
      test_pair({$urandom_range(0, 255), 8'h10}, {$urandom_range(256, 511), 8'h20});
    test_backpressure();
    test_overlap();
    test_stray();
    test_reset_mid();
    test_read(1'b1, 4'h9, 32'h0000_0c40, rand_line(), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
